ryu_controller: RTL and testbench

RYU_CONTROLLER -- requirements
Module: ryu_controller

---
 rtl/ryu_controller.sv | 198 +++++++++++++++++++
 tb/tb_ryu_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ryu_controller.sv
// Ryu fighter controller: pose FSM, walk/jump motion and punch hitbox timing.
// All updates are gated by frame_tick; reset is synchronous and active-high.
module ryu_controller #(
   parameter logic [9:0]        X_START      = 10'd100,
   parameter logic [9:0]        X_MIN        = 10'd0,
   parameter logic [9:0]        X_MAX        = 10'd560,
   parameter logic [9:0]        GROUND_Y     = 10'd280,
   parameter logic [9:0]        WALK_STEP    = 10'd2,
   parameter logic signed [7:0] JUMP_V0      = 8'sd12,
   parameter logic signed [7:0] GRAVITY      = 8'sd1,
   parameter logic [3:0]        PUNCH_FRAMES = 4'd12,
   parameter logic [3:0]        HIT_FIRST    = 4'd4,
   parameter logic [3:0]        HIT_LAST     = 4'd8
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_punch,
   input  logic       dead,
   output logic [9:0] RyuX,
   output logic [9:0] RyuY,
   output logic [2:0] sprite,
   output logic       punch_active
);

   // State codes double as the sprite pose codes.
   typedef enum logic [2:0] {
      STAND  = 3'd0,
      PUNCH  = 3'd1,
      JUMP   = 3'd2,
      CROUCH = 3'd3,
      WALK_L = 3'd4,
      WALK_R = 3'd5,
      DEATH  = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [9:0]         x_d, y_d;
   logic signed [7:0]  vy_q, vy_d;
   logic signed [1:0]  drift_q, drift_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               armed_q, armed_d;
   logic               pa_d;

   // Jump step inputs: live values while airborne, launch values on entry.
   logic signed [7:0]  jump_vy;
   logic signed [1:0]  jump_drift;
   logic signed [1:0]  key_drift;
   logic signed [10:0] jump_y_calc;
   logic [9:0]         jump_x;
   logic               jump_land;

   function automatic logic [9:0] step_left(input logic [9:0] x);
      if (x < X_MIN + WALK_STEP)
         return X_MIN;
      return x - WALK_STEP;
   endfunction

   function automatic logic [9:0] step_right(input logic [9:0] x);
      if (x > X_MAX - WALK_STEP)
         return X_MAX;
      return x + WALK_STEP;
   endfunction

   function automatic logic in_hit_window(input logic [3:0] c);
      return (c >= HIT_FIRST) && (c <= HIT_LAST);
   endfunction

   assign sprite = state_q;

   // Register all state; reset restores the spawn pose.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_q      <= STAND;
         RyuX         <= X_START;
         RyuY         <= GROUND_Y;
         vy_q         <= '0;
         drift_q      <= '0;
         cnt_q        <= '0;
         armed_q      <= 1'b1;
         punch_active <= 1'b0;
      end else begin
         state_q      <= state_d;
         RyuX         <= x_d;
         RyuY         <= y_d;
         vy_q         <= vy_d;
         drift_q      <= drift_d;
         cnt_q        <= cnt_d;
         armed_q      <= armed_d;
         punch_active <= pa_d;
      end
   end

   // One jump physics step, shared by the launch tick and airborne ticks.
   always_comb begin
      key_drift = 2'sd0;
      if (key_left && !key_right)
         key_drift = -2'sd1;
      else if (key_right && !key_left)
         key_drift = 2'sd1;

      if (state_q == JUMP) begin
         jump_vy    = vy_q;
         jump_drift = drift_q;
      end else begin
         jump_vy    = JUMP_V0;
         jump_drift = key_drift;
      end

      jump_y_calc = $signed({1'b0, RyuY}) - {{3{jump_vy[7]}}, jump_vy};
      jump_land   = (jump_y_calc >= $signed({1'b0, GROUND_Y})) && (jump_vy <= 8'sd0);

      case (jump_drift)
         -2'sd1:  jump_x = step_left(RyuX);
         2'sd1:   jump_x = step_right(RyuX);
         default: jump_x = RyuX;
      endcase
   end

   // Next-state and datapath updates, applied only on frame ticks.
   always_comb begin
      state_d = state_q;
      x_d     = RyuX;
      y_d     = RyuY;
      vy_d    = vy_q;
      drift_d = drift_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      pa_d    = punch_active;

      if (frame_tick) begin
         pa_d = 1'b0;
         if (!key_punch)
            armed_d = 1'b1;

         if (dead) begin
            state_d = DEATH;
            y_d     = GROUND_Y;
         end else begin
            case (state_q)
               DEATH: begin
                  state_d = DEATH;
               end
               PUNCH: begin
                  if (cnt_q == 4'(PUNCH_FRAMES - 4'd1)) begin
                     state_d = STAND;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                     pa_d  = in_hit_window(cnt_q + 4'd1);
                  end
               end
               JUMP: begin
                  x_d = jump_x;
                  if (jump_land) begin
                     y_d     = GROUND_Y;
                     state_d = STAND;
                  end else begin
                     y_d = jump_y_calc[9:0];
                  end
                  vy_d = jump_vy - GRAVITY;
               end
               default: begin
                  if (key_punch && armed_q) begin
                     state_d = PUNCH;
                     cnt_d   = '0;
                     armed_d = 1'b0;
                     pa_d    = in_hit_window('0);
                  end else if (key_up) begin
                     // Launch tick already performs the first physics step.
                     state_d = JUMP;
                     drift_d = jump_drift;
                     x_d     = jump_x;
                     y_d     = jump_y_calc[9:0];
                     vy_d    = jump_vy - GRAVITY;
                  end else if (key_down) begin
                     state_d = CROUCH;
                  end else if (key_left && key_right) begin
                     state_d = STAND;
                  end else if (key_left) begin
                     state_d = WALK_L;
                     x_d     = step_left(RyuX);
                  end else if (key_right) begin
                     state_d = WALK_R;
                     x_d     = step_right(RyuX);
                  end else begin
                     state_d = STAND;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ryu_controller.sv
// Directed-vector bench for ryu_controller.
module tb_ryu_controller;

   localparam logic [4:0] K_N = 5'b00000;
   localparam logic [4:0] K_L = 5'b10000;
   localparam logic [4:0] K_R = 5'b01000;
   localparam logic [4:0] K_U = 5'b00100;
   localparam logic [4:0] K_D = 5'b00010;
   localparam logic [4:0] K_P = 5'b00001;

   typedef struct {
      logic        rst;
      logic        tick;
      logic [4:0]  keys;
      logic        dead;
      int unsigned rep;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [2:0]  spr;
      logic        pa;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0;
   logic       key_down = 1'b0, key_punch = 1'b0, dead = 1'b0;
   logic [9:0] RyuX, RyuY;
   logic [2:0] sprite;
   logic       punch_active;

   int n_vec  = 0;
   int n_fail = 0;
   vec_t vecs[$];

   ryu_controller dut (
      .vga_clk      (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .key_left     (key_left),
      .key_right    (key_right),
      .key_up       (key_up),
      .key_down     (key_down),
      .key_punch    (key_punch),
      .dead         (dead),
      .RyuX         (RyuX),
      .RyuY         (RyuY),
      .sprite       (sprite),
      .punch_active (punch_active)
   );

   always #5 clk = ~clk;

   task automatic add(input logic rst, input logic tick, input logic [4:0] keys,
                      input logic dd, input int unsigned rep, input logic [9:0] x,
                      input logic [9:0] y, input logic [2:0] spr, input logic pa);
      vec_t v;
      v.rst = rst; v.tick = tick; v.keys = keys; v.dead = dd; v.rep = rep;
      v.x = x; v.y = y; v.spr = spr; v.pa = pa;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic tick, input logic [4:0] keys,
                        input logic dd);
      reset      = rst;
      frame_tick = tick;
      {key_left, key_right, key_up, key_down, key_punch} = keys;
      dead       = dd;
   endtask

   // One clock with the given inputs; outputs sampled 1ns after the edge.
   task automatic cycle(input logic rst, input logic tick, input logic [4:0] keys,
                        input logic dd);
      @(negedge clk);
      drive(rst, tick, keys, dd);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [9:0] x, input logic [9:0] y,
                        input logic [2:0] spr, input logic pa);
      n_vec++;
      if (RyuX !== x || RyuY !== y || sprite !== spr || punch_active !== pa) begin
         n_fail++;
         $display("FAIL %s: got x=%0d y=%0d sprite=%0d pa=%0b, expected x=%0d y=%0d sprite=%0d pa=%0b",
                  name, RyuX, RyuY, sprite, punch_active, x, y, spr, pa);
      end
   endtask

   initial begin
      int        exp_y, exp_vy;
      logic      landed;
      logic [2:0] exp_spr;
      logic       exp_pa;

      // rst tick keys dead rep | x y sprite pa
      add(1, 0, K_N,       0, 1,   100, 280, 0, 0);
      add(0, 0, K_R,       0, 5,   100, 280, 0, 0);
      add(0, 1, K_R,       0, 10,  120, 280, 5, 0);
      add(0, 0, K_R,       0, 3,   120, 280, 5, 0);
      add(0, 1, K_L | K_R, 0, 1,   120, 280, 0, 0);
      add(0, 1, K_D,       0, 1,   120, 280, 3, 0);
      add(0, 1, K_D | K_R, 0, 1,   120, 280, 3, 0);
      add(0, 1, K_R,       0, 1,   122, 280, 5, 0);
      add(0, 1, K_L,       0, 59,  4,   280, 4, 0);
      add(0, 1, K_L,       0, 1,   2,   280, 4, 0);
      add(0, 1, K_L,       0, 1,   0,   280, 4, 0);
      add(0, 1, K_L,       0, 3,   0,   280, 4, 0);
      add(0, 1, K_N,       0, 1,   0,   280, 0, 0);
      add(0, 1, K_R,       0, 300, 560, 280, 5, 0);
      add(0, 1, K_N,       0, 1,   560, 280, 0, 0);
      add(1, 1, K_R,       0, 1,   100, 280, 0, 0);
      add(0, 1, K_U,       0, 1,   100, 268, 2, 0);
      add(0, 1, K_N,       0, 11,  100, 202, 2, 0);
      add(0, 1, K_N,       0, 1,   100, 202, 2, 0);
      add(0, 1, K_N,       0, 11,  100, 268, 2, 0);
      add(0, 1, K_N,       0, 1,   100, 280, 0, 0);
      add(0, 1, K_U | K_R, 0, 1,   102, 268, 2, 0);
      add(0, 1, K_R,       0, 24,  150, 280, 0, 0);
      add(0, 1, K_P,       0, 1,   150, 280, 1, 0);
      add(0, 1, K_P | K_L | K_U, 0, 3, 150, 280, 1, 0);
      add(0, 1, K_P,       0, 1,   150, 280, 1, 1);
      add(0, 1, K_P,       0, 4,   150, 280, 1, 1);
      add(0, 1, K_P,       0, 1,   150, 280, 1, 0);
      add(0, 1, K_P,       0, 2,   150, 280, 1, 0);
      add(0, 1, K_P,       0, 1,   150, 280, 0, 0);
      add(0, 1, K_P,       0, 17,  150, 280, 0, 0);
      add(0, 1, K_N,       0, 1,   150, 280, 0, 0);
      add(0, 1, K_P,       0, 1,   150, 280, 1, 0);
      add(0, 1, K_N,       0, 12,  150, 280, 0, 0);
      add(0, 1, K_U,       0, 1,   150, 268, 2, 0);
      add(0, 1, K_N,       0, 3,   150, 238, 2, 0);
      add(0, 1, K_N,       1, 1,   150, 280, 6, 0);
      add(0, 1, K_R | K_U | K_P, 0, 5, 150, 280, 6, 0);
      add(0, 1, K_L,       1, 2,   150, 280, 6, 0);
      add(1, 0, K_N,       0, 1,   100, 280, 0, 0);

      foreach (vecs[i]) begin
         for (int unsigned r = 0; r < vecs[i].rep; r++)
            cycle(vecs[i].rst, vecs[i].tick, vecs[i].keys, vecs[i].dead);
         check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].spr, vecs[i].pa);
      end

      // Held punch, tick by tick: 12 punch frames, hitbox on counter 4..8, no retrigger.
      for (int t = 1; t <= 30; t++) begin
         cycle(0, 1, K_P, 0);
         exp_spr = (t <= 12) ? 3'd1 : 3'd0;
         exp_pa  = (t >= 5 && t <= 9);
         check($sformatf("punch_t%0d", t), 100, 280, exp_spr, exp_pa);
      end
      cycle(0, 1, K_N, 0);
      check("punch_release", 100, 280, 0, 0);
      cycle(0, 1, K_P, 0);
      check("punch_rearm", 100, 280, 1, 0);

      // Reset mid-punch, then follow a vertical jump against a small physics model.
      cycle(1, 0, K_P, 0);
      check("reset_mid_punch", 100, 280, 0, 0);
      exp_y  = 280;
      exp_vy = 12;
      landed = 1'b0;
      for (int t = 1; t <= 40 && !landed; t++) begin
         cycle(0, 1, (t == 1) ? K_U : K_N, 0);
         if (exp_y - exp_vy >= 280 && exp_vy <= 0) begin
            exp_y  = 280;
            landed = 1'b1;
         end else begin
            exp_y = exp_y - exp_vy;
         end
         exp_vy = exp_vy - 1;
         check($sformatf("jump_t%0d", t), 100, 10'(exp_y), landed ? 3'd0 : 3'd2, 0);
      end

      @(negedge clk);
      drive(0, 0, K_N, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
